// File: rtl/fmap_addr_seq.sv
// fmap_addr_seq: decodes a layer opcode into feature-map base slots and
// streams every pixel address of those maps over a valid/ready handshake.
module fmap_addr_seq #(
  parameter int FMAP_W       = 64,
  parameter int FMAP_H       = 64,
  parameter int NUM_CH       = 3,
  parameter int MAX_FMAP     = 67,
  parameter int FIRST_SEQ_OP = 16,
  parameter int LAST_OP      = 37,
  parameter int OP_W         = 6,
  parameter int ADDR_W       = 19,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [OP_W-1:0]   i_opcode,
  input  logic              i_abort,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [CH_W-1:0]   o_ch,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int COL_W = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
  localparam int ROW_W = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DONE,
    ERR
  } stateT;

  stateT state;
  stateT stateNext;

  logic [OP_W-1:0]   opReg;
  logic [ADDR_W-1:0] base    [NUM_CH];
  logic [ADDR_W-1:0] baseNew [NUM_CH];
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] maskNew;
  logic [ADDR_W-1:0] idxBase;

  logic [CH_W-1:0]   chIdx;
  logic [CH_W-1:0]   firstCh;
  logic [CH_W-1:0]   lastCh;
  logic [CH_W-1:0]   nextCh;
  logic [CH_W-1:0]   firstNew;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] rowOff;

  logic fire;
  logic lastCol;
  logic lastRow;
  logic lastChHit;

  always_comb begin : decode
    idxBase = '0;
    maskNew = '0;
    baseNew = '{default: '0};
    unique case (1'b1)
      (opReg < OP_W'(FIRST_SEQ_OP)):
        idxBase = '0;
      default:
        idxBase = (ADDR_W'(opReg) - ADDR_W'(FIRST_SEQ_OP)
                   + ADDR_W'(1)) * ADDR_W'(NUM_CH);
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      maskNew[c] = (idxBase + ADDR_W'(c)) < ADDR_W'(MAX_FMAP);
      baseNew[c] = (idxBase + ADDR_W'(c))
                   * ADDR_W'(FMAP_W * FMAP_H);
    end
  end

  // descending scan leaves the lowest matching channel in each result
  always_comb begin : chSel
    firstCh  = '0;
    lastCh   = '0;
    nextCh   = '0;
    firstNew = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) firstCh = CH_W'(i);
      if (maskNew[i]) firstNew = CH_W'(i);
      if (mask[i] && (CH_W'(i) > chIdx)) nextCh = CH_W'(i);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (mask[i]) lastCh = CH_W'(i);
    end
  end

  assign fire      = (state == RUN) && i_ready && !i_abort;
  assign lastCol   = (col == COL_W'(FMAP_W - 1));
  assign lastRow   = (row == ROW_W'(FMAP_H - 1));
  assign lastChHit = (chIdx == lastCh);

  always_comb begin : fsmNext
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          if (i_opcode > OP_W'(LAST_OP)) stateNext = ERR;
          else stateNext = LOAD;
        end
      end
      LOAD: stateNext = (|maskNew) ? RUN : DONE;
      RUN: begin
        if (fire && lastChHit && lastCol && lastRow)
          stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (i_abort) stateNext = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= IDLE;
      opReg  <= '0;
      base   <= '{default: '0};
      mask   <= '0;
      chIdx  <= '0;
      col    <= '0;
      row    <= '0;
      rowOff <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && i_start) opReg <= i_opcode;
      if (state == LOAD) begin
        base   <= baseNew;
        mask   <= maskNew;
        chIdx  <= firstNew;
        col    <= '0;
        row    <= '0;
        rowOff <= '0;
      end else if (fire) begin
        if (lastChHit) begin
          chIdx <= firstCh;
          if (lastCol) begin
            col    <= '0;
            row    <= row + ROW_W'(1);
            rowOff <= rowOff + ADDR_W'(FMAP_W);
          end else begin
            col <= col + COL_W'(1);
          end
        end else begin
          chIdx <= nextCh;
        end
      end
    end
  end

  assign o_valid = (state == RUN);
  assign o_addr  = base[chIdx] + rowOff + ADDR_W'(col);
  assign o_ch    = chIdx;
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);
  assign o_err   = (state == ERR);

endmodule

// File: tb/tb_fmap_addr_seq.sv
// tb_fmap_addr_seq: directed + random back-pressure checks of the
// address sequencer against an arithmetic slot/pixel reference.
module tb_fmap_addr_seq;

  localparam int AW = 19;
  localparam int OW = 6;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_start;
  logic [OW-1:0] i_opcode;
  logic          i_abort;
  logic          i_ready;
  logic          o_valid;
  logic [AW-1:0] o_addr;
  logic [1:0]    o_ch;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  fmap_addr_seq dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_start (i_start),
    .i_opcode(i_opcode),
    .i_abort (i_abort),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_addr  (o_addr),
    .o_ch    (o_ch),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // k-th transfer: pixel k/n of the (k mod n)-th enabled map
  function automatic void refBeat(input int op, input int k,
                                  output int addr, output int ch);
    int idxQ[$];
    int chQ[$];
    int n;
    for (int c = 0; c < 3; c++) begin
      int id;
      id = (op < 16) ? c : (op - 16 + 1) * 3 + c;
      if (id < 67) begin
        idxQ.push_back(id);
        chQ.push_back(c);
      end
    end
    n    = idxQ.size();
    addr = idxQ[k % n] * 4096 + k / n;
    ch   = chQ[k % n];
  endfunction

  task automatic stream(input int op, input int nXfer,
                        input int pct, input bit glitch,
                        output int k);
    int cyc;
    int badAt;
    int a;
    int c;
    bit rdy;
    k     = 0;
    cyc   = 0;
    badAt = bad;
    i_opcode = OW'(op);
    i_start  = 1'b1;
    tick;
    i_start = 1'b0;
    check("load_busy", o_busy, 1);
    check("load_valid", o_valid, 0);
    while (k < nXfer && cyc < nXfer * 20 + 20 && bad == badAt) begin
      rdy = (pct >= 100) || ($urandom_range(0, 99) < pct);
      i_ready = rdy;
      i_start = glitch && (k == 5);
      if (i_start) i_opcode = OW'(37);
      if (o_valid) begin
        refBeat(op, k, a, c);
        check("addr", o_addr, a);
        check("ch", o_ch, c);
        if (rdy) k++;
      end else if (k > 0) begin
        check("valid_hold", o_valid, 1);
      end
      tick;
      cyc++;
    end
    i_start = 1'b0;
    i_ready = 1'b0;
    check("xfer_count", k, nXfer);
  endtask

  task automatic checkDone(input string tag);
    check({tag, "_done"}, o_done, 1);
    check({tag, "_busy"}, o_busy, 1);
    check({tag, "_valid"}, o_valid, 0);
    tick;
    check({tag, "_done_low"}, o_done, 0);
    check({tag, "_idle"}, o_busy, 0);
  endtask

  task automatic abortRun(input string tag);
    i_ready = 1'b1;
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0;
    i_ready = 1'b0;
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_busy"}, o_busy, 0);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_nodone"}, o_done, 0);
      tick;
    end
  endtask

  initial begin
    int k;
    int errOps[2];
    errOps   = '{38, 63};
    i_rstn   = 1'b1;
    i_start  = 1'b0;
    i_abort  = 1'b0;
    i_ready  = 1'b0;
    i_opcode = '0;
    #1 i_rstn = 1'b0;
    #11;
    check("rst_valid", o_valid, 0);
    check("rst_addr", o_addr, 0);
    check("rst_ch", o_ch, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    tick;
    i_rstn = 1'b1;
    tick;

    stream(5, 12288, 100, 1'b0, k);
    checkDone("op5");

    stream(37, 4096, 100, 1'b0, k);
    checkDone("op37");

    foreach (errOps[j]) begin
      i_opcode = OW'(errOps[j]);
      i_start  = 1'b1;
      tick;
      i_start = 1'b0;
      check("err_pulse", o_err, 1);
      check("err_busy", o_busy, 1);
      check("err_valid", o_valid, 0);
      tick;
      check("err_clear", o_err, 0);
      check("err_idle", o_busy, 0);
      check("err_novalid", o_valid, 0);
    end

    // start pulse mid-run must not disturb the op0 stream
    stream(0, 40, 100, 1'b1, k);
    abortRun("abort0");

    stream(16, 30, 100, 1'b0, k);
    abortRun("abort16");

    stream(36, 30, 100, 1'b0, k);
    #2 i_rstn = 1'b0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_busy", o_busy, 0);
    check("arst_addr", o_addr, 0);
    check("arst_ch", o_ch, 0);
    tick;
    i_rstn = 1'b1;
    check("arst_nodone", o_done, 0);
    tick;

    stream(20, 12288, 50, 1'b0, k);
    checkDone("op20");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
